// File: rtl/tick_period_meter.sv
// ---------------------------------------------------------------------------
// tick_period_meter
//
// Purpose:
//   Measures the spacing between tick events from a prescaler. The result is
//   reported as a prescaler value: a tick every N+1 enabled cycles reads as N.
//   When MATCH_N consecutive intervals agree, the meter locks and publishes
//   the recovered prescaler value. A period change while locked raises err.
//   A gap that is too long to measure raises err and the meter restarts its
//   search.
//
// Parameters:
//   MATCH_N     number of consecutive equal intervals needed to lock (1..7)
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous active-low reset
//   en          count enable; when low all state and outputs hold
//   tick        tick stream; tick & en marks one event
//   meas        most recent measured interval (prescaler value)
//   meas_valid  1-cycle pulse when meas is updated
//   psc_out     recovered prescaler value, updated only when lock is acquired
//   lock        high while the tick period is stable
//   err         1-cycle pulse on overflow or on a period change while locked
// ---------------------------------------------------------------------------
module tick_period_meter #(
    parameter int MATCH_N = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tick,
    output logic [4:0] meas,
    output logic       meas_valid,
    output logic [4:0] psc_out,
    output logic       lock,
    output logic       err
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQ     = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [2:0] MATCH_W = 3'(MATCH_N);

    state_t     state_q, state_d;
    logic [5:0] g_q, g_d;
    logic [4:0] cand_q, cand_d;
    logic [2:0] mc_q, mc_d;
    logic [4:0] meas_q, meas_d;
    logic       meas_valid_q, meas_valid_d;
    logic [4:0] psc_q, psc_d;
    logic       lock_q, lock_d;
    logic       err_q, err_d;

    logic       event_s;
    logic [4:0] g_low_s;
    logic [2:0] mc_inc_s;

    assign event_s  = en & tick;
    // Outside HUNT the counter never exceeds 31, so the low five bits are the
    // whole interval whenever it is measured.
    assign g_low_s  = g_q[4:0];
    assign mc_inc_s = mc_q + 3'd1;

    // Next-state logic for the measurement FSM, counters and output registers.
    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        cand_d       = cand_q;
        mc_d         = mc_q;
        meas_d       = meas_q;
        psc_d        = psc_q;
        lock_d       = lock_q;
        meas_valid_d = 1'b0;
        err_d        = 1'b0;

        if (event_s) begin
            g_d = 6'd0;
            case (state_q)
                HUNT: begin
                    // First edge only opens an interval; nothing to report yet.
                    state_d = ACQ;
                end
                ACQ: begin
                    meas_d       = g_low_s;
                    meas_valid_d = 1'b1;
                    cand_d       = g_low_s;
                    mc_d         = 3'd1;
                    if (MATCH_W == 3'd1) begin
                        lock_d  = 1'b1;
                        psc_d   = g_low_s;
                        state_d = LOCKED;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
                CONFIRM: begin
                    meas_d       = g_low_s;
                    meas_valid_d = 1'b1;
                    if (g_low_s == cand_q) begin
                        mc_d = mc_inc_s;
                        if (mc_inc_s >= MATCH_W) begin
                            lock_d  = 1'b1;
                            psc_d   = cand_q;
                            state_d = LOCKED;
                        end else begin
                            state_d = CONFIRM;
                        end
                    end else begin
                        cand_d  = g_low_s;
                        mc_d    = 3'd1;
                        state_d = CONFIRM;
                    end
                end
                LOCKED: begin
                    meas_d       = g_low_s;
                    meas_valid_d = 1'b1;
                    if (g_low_s != cand_q) begin
                        // Period changed: drop lock but keep the last psc_out.
                        err_d   = 1'b1;
                        lock_d  = 1'b0;
                        cand_d  = g_low_s;
                        mc_d    = 3'd1;
                        state_d = CONFIRM;
                    end else begin
                        state_d = LOCKED;
                    end
                end
                default: begin
                    state_d = HUNT;
                    lock_d  = 1'b0;
                end
            endcase
        end else if (en) begin
            if (state_q == HUNT) begin
                // No measurement in progress: saturate instead of overflowing.
                if (g_q < 6'd32) begin
                    g_d = g_q + 6'd1;
                end else begin
                    g_d = g_q;
                end
            end else if (g_q >= 6'd31) begin
                // Interval too long to represent in five bits.
                err_d   = 1'b1;
                lock_d  = 1'b0;
                g_d     = 6'd0;
                state_d = HUNT;
            end else begin
                g_d = g_q + 6'd1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            g_q          <= 6'd0;
            cand_q       <= 5'd0;
            mc_q         <= 3'd0;
            meas_q       <= 5'd0;
            meas_valid_q <= 1'b0;
            psc_q        <= 5'd0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            cand_q       <= cand_d;
            mc_q         <= mc_d;
            meas_q       <= meas_d;
            meas_valid_q <= meas_valid_d;
            psc_q        <= psc_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
        end
    end

    assign meas       = meas_q;
    assign meas_valid = meas_valid_q;
    assign psc_out    = psc_q;
    assign lock       = lock_q;
    assign err        = err_q;

endmodule
